// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map is indexed {row, col}; COL_RESET is the first column driven.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_t;

  // Element [idx] is the hex value of key {r, c}
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [1:0] low_idx(
    input logic [3:0] v
  );
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] col_rot(
    input logic [3:0] v
  );
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous inputs.
// Resets to all ones, matching an idle pulled-up bus.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and two-digit key history.
// Define KEYPAD_SCANNER_REPEAT_EN for auto-repeat while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd6000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] left,
  output logic [3:0] right
);

  localparam logic [15:0] SETTLE    = SCAN_DIV >> 1;
  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;
  localparam logic [19:0] DEB_LAST  = DEBOUNCE_CYCLES - 20'd1;

  if (SCAN_DIV < 16'd4) begin : g_bad_div
    $error("SCAN_DIV must be at least 4");
  end
  if (REPEAT_CYCLES == 24'd0) begin : g_bad_rep
    $error("REPEAT_CYCLES must be non-zero");
  end

  logic [3:0]  rs;
  kp_state_t   state_q;
  logic [15:0] scnt_q;
  logic [19:0] dcnt_q;
  logic [1:0]  r_q;
  logic [1:0]  c_q;
  logic [3:0]  col_q;
  logic [3:0]  code_q;
  logic        valid_q;
  logic [3:0]  left_q;
  logic [3:0]  right_q;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam logic [23:0] REP_LAST = REPEAT_CYCLES - 24'd1;
  logic [23:0] rcnt_q;
`endif

  sync_2ff #(
    .W (4)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (row),
    .q_o   (rs)
  );

  logic [3:0] map_key;
  logic       row_hi;

  assign map_key = KEY_MAP[{r_q, c_q}];
  assign row_hi  = rs[r_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      scnt_q  <= '0;
      dcnt_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      col_q   <= COL_RESET;
      code_q  <= '0;
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          // Rows only trusted once the new column has settled
          if (scnt_q >= SETTLE && rs != 4'hF) begin
            r_q     <= low_idx(rs);
            c_q     <= low_idx(col_q);
            dcnt_q  <= '0;
            state_q <= DEBOUNCE;
          end else if (scnt_q == SCAN_LAST) begin
            col_q  <= col_rot(col_q);
            scnt_q <= '0;
          end else begin
            scnt_q <= scnt_q + 16'd1;
          end
        end
        DEBOUNCE: begin
          if (row_hi) begin
            scnt_q  <= '0;
            state_q <= SCAN;
          end else if (dcnt_q == DEB_LAST) begin
            code_q  <= map_key;
            left_q  <= right_q;
            right_q <= map_key;
            valid_q <= 1'b1;
            state_q <= HELD;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rcnt_q  <= '0;
`endif
          end else begin
            dcnt_q <= dcnt_q + 20'd1;
          end
        end
        HELD: begin
          if (row_hi) begin
            dcnt_q  <= '0;
            state_q <= RELEASE;
          end
`ifdef KEYPAD_SCANNER_REPEAT_EN
          else if (rcnt_q == REP_LAST) begin
            left_q  <= right_q;
            right_q <= code_q;
            valid_q <= 1'b1;
            rcnt_q  <= '0;
          end else begin
            rcnt_q <= rcnt_q + 24'd1;
          end
`endif
        end
        RELEASE: begin
          if (!row_hi) begin
            state_q <= HELD;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rcnt_q  <= '0;
`endif
          end else if (dcnt_q == DEB_LAST) begin
            col_q   <= col_rot(col_q);
            scnt_q  <= '0;
            state_q <= SCAN;
          end else begin
            dcnt_q <= dcnt_q + 20'd1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign left      = left_q;
  assign right     = right_q;

endmodule
